// File: rtl/fixed_vec_recip_if.sv
// Handshake and data bundle for fixed_vec_recip: operand vector in, reciprocal
// vector plus per-channel flags out, each side with valid/ready flow control.
interface fixed_vec_recip_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_v;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*WIDTH-1:0] out_v;
    logic [CHANNELS-1:0]       out_div0;
    logic [CHANNELS-1:0]       out_sat;

    modport master (
        output in_valid, in_v, out_ready,
        input  in_ready, out_valid, out_v, out_div0, out_sat
    );

    modport slave (
        input  in_valid, in_v, out_ready,
        output in_ready, out_valid, out_v, out_div0, out_sat
    );
endinterface

// File: rtl/fixed_vec_recip.sv
// N-channel signed fixed-point reciprocal: restoring division of 2^(2*FRAC) by |x|,
// all channels in lockstep, BITS_PER_CYCLE quotient bits per clock, saturating output.
module fixed_vec_recip #(
    parameter int WIDTH          = 32,
    parameter int FRAC           = 16,
    parameter int CHANNELS       = 3,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic              clk,
    input logic              resetn,
    fixed_vec_recip_if.slave bus
);
    localparam int QBITS = 2 * FRAC + 1;
    localparam int ITER  = (QBITS + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int QW    = ITER * BITS_PER_CYCLE;
    // Leading zero dividend bits when QBITS is not a multiple of BITS_PER_CYCLE.
    localparam int PAD   = QW - QBITS;
    localparam int CW    = ((QW > WIDTH) ? QW : WIDTH) + 1;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_in_ready;
    logic   w_load;
    logic   w_step;
    logic   w_fix;

    logic [CNT_W-1:0]          r_cnt;
    logic                      r_sign [CHANNELS];
    logic                      r_zero [CHANNELS];
    logic [WIDTH-1:0]          r_mag  [CHANNELS];
    logic [WIDTH:0]            r_rem  [CHANNELS];
    logic [QW-1:0]             r_quo  [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] r_out_v;
    logic [CHANNELS-1:0]       r_out_div0;
    logic [CHANNELS-1:0]       r_out_sat;

    logic [WIDTH-1:0]          w_x     [CHANNELS];
    logic [WIDTH-1:0]          w_abs   [CHANNELS];
    logic [WIDTH:0]            w_rem_nxt [CHANNELS];
    logic [QW-1:0]             w_quo_nxt [CHANNELS];
    logic [BITS_PER_CYCLE-1:0] w_div_bit;
    logic [CHANNELS*WIDTH-1:0] w_res_v;
    logic [CHANNELS-1:0]       w_res_div0;
    logic [CHANNELS-1:0]       w_res_sat;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reset is asynchronous on resetn low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = S_DIV;
                end
            end
            S_DIV: begin
                w_step = 1'b1;
                if (r_cnt == '0) w_state_next = S_FIX;
            end
            S_FIX: begin
                w_fix        = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_in_ready = 1'b1;
                    if (bus.in_valid) begin
                        w_load       = 1'b1;
                        w_state_next = S_DIV;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // |x| as WIDTH-bit unsigned: the most negative input maps to 2^(WIDTH-1).
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_x[c]   = bus.in_v[c*WIDTH +: WIDTH];
            w_abs[c] = w_x[c][WIDTH-1] ? (~w_x[c] + WIDTH'(1)) : w_x[c];
        end
    end

    // The dividend is a single 1 followed by 2*FRAC zeros, fed MSB first.
    always_comb begin
        w_div_bit = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            w_div_bit[j] = (r_cnt == CNT_W'(ITER - 1)) && (j == PAD);
        end
    end

    always_comb begin
        logic [WIDTH:0] v_rem;
        logic [QW-1:0]  v_quo;
        v_rem = '0;
        v_quo = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            v_rem = r_rem[c];
            v_quo = r_quo[c];
            for (int j = BITS_PER_CYCLE - 1; j >= 0; j--) begin
                v_rem = {v_rem[WIDTH-1:0], w_div_bit[BITS_PER_CYCLE-1-j]};
                v_quo = {v_quo[QW-2:0], 1'b0};
                if (v_rem >= {1'b0, r_mag[c]}) begin
                    v_rem    = v_rem - {1'b0, r_mag[c]};
                    v_quo[0] = 1'b1;
                end
            end
            w_rem_nxt[c] = v_rem;
            w_quo_nxt[c] = v_quo;
        end
    end

    always_comb begin
        logic [CW-1:0]    v_q;
        logic [WIDTH-1:0] v_mag;
        w_res_v    = '0;
        w_res_div0 = '0;
        w_res_sat  = '0;
        v_q        = '0;
        v_mag      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            v_q = CW'(r_quo[c]);
            if (r_zero[c]) begin
                v_mag         = MAXP;
                w_res_div0[c] = 1'b1;
            end else if (v_q > CW'(MAXP)) begin
                v_mag        = MAXP;
                w_res_sat[c] = 1'b1;
            end else begin
                v_mag = v_q[WIDTH-1:0];
            end
            w_res_v[c*WIDTH +: WIDTH] = (r_sign[c] && !r_zero[c]) ? (~v_mag + WIDTH'(1)) : v_mag;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_out_v    <= '0;
            r_out_div0 <= '0;
            r_out_sat  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_sign[c] <= 1'b0;
                r_zero[c] <= 1'b0;
                r_mag[c]  <= '0;
                r_rem[c]  <= '0;
                r_quo[c]  <= '0;
            end
        end else begin
            if (w_load) begin
                r_cnt <= CNT_W'(ITER - 1);
                for (int c = 0; c < CHANNELS; c++) begin
                    r_sign[c] <= w_x[c][WIDTH-1];
                    r_zero[c] <= (w_x[c] == '0);
                    r_mag[c]  <= w_abs[c];
                    r_rem[c]  <= '0;
                    r_quo[c]  <= '0;
                end
            end else if (w_step) begin
                if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                for (int c = 0; c < CHANNELS; c++) begin
                    r_rem[c] <= w_rem_nxt[c];
                    r_quo[c] <= w_quo_nxt[c];
                end
            end
            if (w_fix) begin
                r_out_v    <= w_res_v;
                r_out_div0 <= w_res_div0;
                r_out_sat  <= w_res_sat;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_v     = r_out_v;
    assign bus.out_div0  = r_out_div0;
    assign bus.out_sat   = r_out_sat;
endmodule
